// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, frame constants and the
// memory-mapped TX address decoded by the data-memory block.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned FRAME_BITS           = 10;
  localparam int unsigned BAUD_W               = 16;
  localparam logic [31:0] UART_TX_ADDR         = 32'h1000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read data; DEPTH must be a
// power of two so the pointers wrap on their own.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // A write into a full queue still lands when the same cycle frees a slot.
  always_comb begin
    pop      = pop_i && (count_q != '0);
    push     = wr_i && ((count_q != FULL_CNT) || pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter fed by the store-side write strobe.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise one holding register.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_we,
  input  logic [7:0] uart_wdata,
  output logic       uart_tx,
  output logic       busy,
  output logic       full,
  output logic       overflow
);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_buffered: CLKS_PER_BIT must be within 2..65535");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;

  logic              q_pop, q_empty, q_full, q_any;
  logic [7:0]        q_rdata;

`ifdef UART_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] q_count;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (uart_we),
    .wdata_i (uart_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign q_any = (q_count != '0);
`else
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (q_pop) hold_valid_d = 1'b0;
    if (uart_we && (!hold_valid_q || q_pop)) begin
      hold_valid_d = 1'b1;
      hold_data_d  = uart_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hold_valid_q <= 1'b0;
    else        hold_valid_q <= hold_valid_d;
  end

  always_ff @(posedge clk) begin
    hold_data_q <= hold_data_d;
  end

  assign q_rdata = hold_data_q;
  assign q_full  = hold_valid_q;
  assign q_empty = !hold_valid_q;
  assign q_any   = hold_valid_q;
`endif

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BAUD_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    q_pop      = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!q_empty) begin
          q_pop   = 1'b1;
          shift_d = q_rdata;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave gap-free.
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!q_empty) begin
            q_pop   = 1'b1;
            shift_d = q_rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so uart_tx has no input path.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    overflow_d = overflow_q || (uart_we && q_full && !q_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign uart_tx  = tx_q;
  assign busy     = (state_q != IDLE) || q_any;
  assign full     = q_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered at CLKS_PER_BIT=4, FIFO_DEPTH=4; the
// expected queue depth follows UART_TX_FIFO_EN.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int MD = DEPTH;
`else
  localparam int MD = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_we = 1'b0;
  logic [7:0] uart_wdata = 8'h00;
  logic       uart_tx, busy, full, overflow;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         nexp;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_we   (uart_we),
    .uart_wdata(uart_wdata),
    .uart_tx   (uart_tx),
    .busy      (busy),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    uart_we = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: decodes every frame on the line and compares it with the scoreboard.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] exp;
    bit         ok, aborted;
    int         k;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        k = cyc; got = '0; ok = 1'b1; aborted = 1'b0;
        for (int j = 1; j <= 39; j++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
          if (j == 2 && uart_tx !== 1'b0) ok = 1'b0;
          if (j >= 6 && j <= 34 && ((j - 6) % 4) == 0) got[(j - 6) / 4] = uart_tx;
          if (j == 38 && uart_tx !== 1'b1) ok = 1'b0;
        end
        if (!aborted) begin
          starts_q.push_back(k);
          chk("frame_start_stop", 32'(ok), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: got %0h expected none", got);
          end else begin
            exp = exp_q.pop_front();
            chk("frame_byte", 32'(got), 32'(exp));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx",   32'(uart_tx),  32'd1);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_full", 32'(full),     32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: bits LSB first 1,0,1,0,0,1,0,1
    starts_q.delete();
    exp_q.push_back(8'hA5);
    uart_we = 1'b1; uart_wdata = 8'hA5;
    @(posedge clk); #1;
    chk("a5_busy_on_write", 32'(busy),    32'd1);
    chk("a5_tx_before_pop", 32'(uart_tx), 32'd1);
    @(negedge clk); uart_we = 1'b0;
    @(posedge clk); #1;
    chk("a5_start_low", 32'(uart_tx), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("a5_start_len", 32'(uart_tx), 32'd0);
    @(posedge clk); #1;
    chk("a5_bit0", 32'(uart_tx), 32'd1);
    repeat (4) @(posedge clk); #1;
    chk("a5_bit1", 32'(uart_tx), 32'd0);
    repeat (31) @(posedge clk); #1;
    chk("a5_stop_high", 32'(uart_tx), 32'd1);
    chk("a5_busy_last", 32'(busy),    32'd1);
    @(posedge clk); #1;
    chk("a5_busy_drop", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // Three writes on consecutive cycles
    starts_q.delete();
    nexp = (MD >= 2) ? 3 : 2;
    for (int i = 0; i < nexp; i++) exp_q.push_back(8'(8'h41 + i));
    for (int i = 0; i < 3; i++) begin
      uart_we = 1'b1; uart_wdata = 8'(8'h41 + i);
      @(negedge clk);
    end
    uart_we = 1'b0;
    chk("abc_ovf", 32'(overflow), (MD == 1) ? 32'd1 : 32'd0);
    wait_idle("abc_idle");
    chk("abc_frames", 32'(starts_q.size()), 32'(nexp));
    chk("abc_contig", 32'(starts_q[$] - starts_q[0]), 32'(40 * (nexp - 1)));
    do_reset();
    @(negedge clk);
    chk("abc_ovf_cleared", 32'(overflow), 32'd0);

    // Six writes: bytes beyond the queue capacity are dropped
    starts_q.delete();
    for (int i = 0; i < 6; i++) if (i <= MD) exp_q.push_back(8'(8'h10 + i));
    for (int i = 0; i < 6; i++) begin
      uart_we = 1'b1; uart_wdata = 8'(8'h10 + i);
      @(negedge clk);
    end
    uart_we = 1'b0;
    chk("six_full", 32'(full),     32'd1);
    chk("six_ovf",  32'(overflow), 32'd1);
    wait_idle("six_idle");
    chk("six_frames",     32'(starts_q.size()), 32'(MD + 1));
    chk("six_ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    @(negedge clk);
    chk("six_ovf_reset",  32'(overflow), 32'd0);
    chk("six_full_reset", 32'(full),     32'd0);

    // Queue full while the last STOP cycle pops: the write must be kept
    starts_q.delete();
    for (int i = 0; i <= MD; i++) exp_q.push_back(8'(8'h60 + i));
    exp_q.push_back(8'h7E);
    for (int i = 0; i <= MD; i++) begin
      uart_we = 1'b1; uart_wdata = 8'(8'h60 + i);
      @(negedge clk);
    end
    uart_we = 1'b0;
    repeat (40 - MD) @(negedge clk);
    chk("pop_full_before", 32'(full), 32'd1);
    uart_we = 1'b1; uart_wdata = 8'h7E;
    @(posedge clk); #1;
    chk("pop_full_after", 32'(full),     32'd1);
    chk("pop_ovf_after",  32'(overflow), 32'd0);
    @(negedge clk); uart_we = 1'b0;
    wait_idle("pop_idle");
    chk("pop_frames", 32'(starts_q.size()), 32'(MD + 2));
    chk("pop_contig", 32'(starts_q[$] - starts_q[0]), 32'(40 * (MD + 1)));
    chk("pop_ovf_end", 32'(overflow), 32'd0);

    // Reset during the data bits abandons the frame and empties the queue
    uart_we = 1'b1; uart_wdata = 8'h3C;
    @(negedge clk);
    uart_wdata = 8'h77;
    @(negedge clk);
    uart_we = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_pre_tx", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_tx",   32'(uart_tx),  32'd1);
    chk("mid_busy", 32'(busy),     32'd0);
    chk("mid_full", 32'(full),     32'd0);
    chk("mid_ovf",  32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    starts_q.delete();
    exp_q.push_back(8'h5A);
    uart_we = 1'b1; uart_wdata = 8'h5A;
    @(negedge clk);
    uart_we = 1'b0;
    wait_idle("post_rst_idle");
    chk("post_rst_frames", 32'(starts_q.size()), 32'd1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
